// File: rtl/sd_data_serial_card_pkg.sv
`default_nettype none
// sd_data_serial_card_pkg -- shared SD DAT-engine constants, state encodings and CRC16 step.
// Rev 1.0
package sd_data_serial_card_pkg;

    localparam int SD_BUS_W        = 4;
    localparam int SD_NAC_DEFAULT  = 2;
    localparam int SD_NCRC_DEFAULT = 2;
    localparam int SD_CNT_W        = 16;

    localparam logic [15:0] SD_CRC16_POLY = 16'h1021;

    localparam logic [3:0] ST_IDLE     = 4'd0;
    localparam logic [3:0] ST_RX_WAIT  = 4'd1;
    localparam logic [3:0] ST_RX_DAT   = 4'd2;
    localparam logic [3:0] ST_RX_CRC   = 4'd3;
    localparam logic [3:0] ST_RX_END   = 4'd4;
    localparam logic [3:0] ST_STAT_GAP = 4'd5;
    localparam logic [3:0] ST_STAT     = 4'd6;
    localparam logic [3:0] ST_BUSY     = 4'd7;
    localparam logic [3:0] ST_TX_WAIT  = 4'd8;
    localparam logic [3:0] ST_TX_START = 4'd9;
    localparam logic [3:0] ST_TX_DAT   = 4'd10;
    localparam logic [3:0] ST_TX_CRC   = 4'd11;
    localparam logic [3:0] ST_TX_END   = 4'd12;

    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic bit_in);
        crc16_step = {crc[14:0], 1'b0} ^ ((bit_in ^ crc[15]) ? SD_CRC16_POLY : 16'h0000);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sd_data_serial_card_crc16.sv
`default_nettype none
// sd_crc_16 -- serial CRC16 (x^16+x^12+x^5+1), zero initial value, one bit per enabled clock.
// Rev 1.0
module sd_crc_16
    import sd_data_serial_card_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        en,
    input  logic        bit_in,
    output logic [15:0] crc
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc <= 16'h0000;
        end else if (clr) begin
            crc <= 16'h0000;
        end else if (en) begin
            crc <= crc16_step(crc, bit_in);
        end
    end

endmodule
`default_nettype wire

// File: rtl/sd_data_serial_card.sv
`default_nettype none
// sd_data_serial_card -- card-side DAT engine: write-block receive with CRC status/busy, read-block transmit.
// Rev 1.0
module sd_data_serial_card #(
    parameter int NAC  = sd_data_serial_card_pkg::SD_NAC_DEFAULT,
    parameter int NCRC = sd_data_serial_card_pkg::SD_NCRC_DEFAULT
) (
    input  logic        sd_clk,
    input  logic        rst_n,
    input  logic [3:0]  DAT_dat_i,
    output logic [3:0]  DAT_dat_o,
    output logic        DAT_oe_o,
    input  logic        bus_width,
    input  logic [11:0] blksize,
    input  logic        start_rx,
    input  logic        start_tx,
    input  logic        abort,
    input  logic [7:0]  busy_cycles,
    output logic [7:0]  rx_data,
    output logic        rx_we,
    input  logic [7:0]  tx_data,
    output logic        tx_rd,
    output logic        done,
    output logic        crc_ok,
    output logic        busy
);
    import sd_data_serial_card_pkg::*;

    localparam logic [SD_CNT_W-1:0] NAC_LAST  = SD_CNT_W'(NAC - 1);
    localparam logic [SD_CNT_W-1:0] NCRC_LAST = SD_CNT_W'(NCRC - 1);

    logic [3:0]          state;
    logic [SD_CNT_W-1:0] cnt;
    logic [7:0]          shreg;
    logic                crc_mis;

    logic [SD_CNT_W-1:0] data_len;
    logic                data_last;
    logic                byte_first;
    logic                byte_last;
    logic [3:0]          active;
    logic                start_bit;
    logic [7:0]          rx_byte;
    logic [7:0]          tx_cur;
    logic [7:0]          tx_next;
    logic [7:0]          busy_len;
    logic                busy_last;
    logic                crc_clr;
    logic                crc_en;
    logic [3:0]          crc_in;
    logic [3:0]          crc_bit;
    logic                crc_err;
    logic                end_ok;
    logic                tok_bit;
    logic [15:0]         crc_val [SD_BUS_W];

    // Data cycles per block: 8 per byte on DAT0, 2 per byte on DAT[3:0].
    assign data_len   = bus_width ? {3'b000, blksize, 1'b0} : {1'b0, blksize, 3'b000};
    assign data_last  = (cnt == data_len - 1'b1);
    assign byte_first = bus_width ? ~cnt[0] : (cnt[2:0] == 3'd0);
    assign byte_last  = bus_width ?  cnt[0] : (&cnt[2:0]);
    assign active     = bus_width ? 4'b1111 : 4'b0001;
    assign start_bit  = bus_width ? (DAT_dat_i == 4'b0000) : ~DAT_dat_i[0];

    assign rx_byte = bus_width ? {shreg[3:0], DAT_dat_i} : {shreg[6:0], DAT_dat_i[0]};

    // The head byte is only valid after the previous pop, so the first bit comes straight from tx_data.
    assign tx_cur  = byte_first ? tx_data : shreg;
    assign tx_next = bus_width ? {tx_cur[3:0], 4'b0000} : {tx_cur[6:0], 1'b0};

    assign busy_len  = (busy_cycles == 8'd0) ? 8'd1 : busy_cycles;
    assign busy_last = (cnt == {8'h00, busy_len - 8'd1});

    assign crc_clr = (state == ST_IDLE) || (state == ST_RX_WAIT) || (state == ST_TX_START);
    assign crc_en  = (state == ST_RX_DAT) || (state == ST_TX_DAT);
    assign crc_in  = (state == ST_RX_DAT) ? DAT_dat_i : DAT_dat_o;

    for (genvar g = 0; g < SD_BUS_W; g++) begin : g_crc
        sd_crc_16 u_crc (
            .clk    (sd_clk),
            .rst_n  (rst_n),
            .clr    (crc_clr),
            .en     (crc_en),
            .bit_in (crc_in[g]),
            .crc    (crc_val[g])
        );
        assign crc_bit[g] = crc_val[g][~cnt[3:0]];
    end

    assign crc_err = |((crc_bit ^ DAT_dat_i) & active);
    assign end_ok  = &(DAT_dat_i | ~active);

    always_comb begin
        tok_bit = 1'b1;
        case (cnt[2:0])
            3'd0:    tok_bit = 1'b0;
            3'd1:    tok_bit = ~crc_ok;
            3'd2:    tok_bit = crc_ok;
            3'd3:    tok_bit = ~crc_ok;
            default: tok_bit = 1'b1;
        endcase
    end

    always_comb begin
        DAT_oe_o  = 1'b0;
        DAT_dat_o = 4'b1111;
        tx_rd     = 1'b0;
        case (state)
            ST_STAT: begin
                DAT_oe_o  = 1'b1;
                DAT_dat_o = {3'b111, tok_bit};
            end
            ST_BUSY: begin
                DAT_oe_o  = 1'b1;
                DAT_dat_o = 4'b1110;
            end
            ST_TX_WAIT, ST_TX_END: begin
                DAT_oe_o  = 1'b1;
            end
            ST_TX_START: begin
                DAT_oe_o  = 1'b1;
                DAT_dat_o = ~active;
            end
            ST_TX_DAT: begin
                DAT_oe_o  = 1'b1;
                DAT_dat_o = bus_width ? tx_cur[7:4] : {3'b111, tx_cur[7]};
                tx_rd     = byte_last;
            end
            ST_TX_CRC: begin
                DAT_oe_o  = 1'b1;
                DAT_dat_o = crc_bit | ~active;
            end
            default: ;
        endcase
    end

    assign busy = (state != ST_IDLE);

    always_ff @(posedge sd_clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            shreg   <= 8'h00;
            crc_mis <= 1'b0;
            rx_data <= 8'h00;
            rx_we   <= 1'b0;
            done    <= 1'b0;
            crc_ok  <= 1'b0;
        end else begin
            rx_we <= 1'b0;
            done  <= 1'b0;
            if (abort) begin
                state <= ST_IDLE;
                cnt   <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        cnt <= '0;
                        if (start_rx) begin
                            state  <= ST_RX_WAIT;
                            crc_ok <= 1'b0;
                        end else if (start_tx) begin
                            state <= (NAC == 0) ? ST_TX_START : ST_TX_WAIT;
                        end
                    end
                    ST_RX_WAIT: begin
                        crc_mis <= 1'b0;
                        cnt     <= '0;
                        if (start_bit) begin
                            state <= ST_RX_DAT;
                        end
                    end
                    ST_RX_DAT: begin
                        shreg <= rx_byte;
                        if (byte_last) begin
                            rx_data <= rx_byte;
                            rx_we   <= 1'b1;
                        end
                        if (data_last) begin
                            state <= ST_RX_CRC;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    ST_RX_CRC: begin
                        if (crc_err) begin
                            crc_mis <= 1'b1;
                        end
                        if (cnt[3:0] == 4'hF) begin
                            state <= ST_RX_END;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    ST_RX_END: begin
                        crc_ok <= ~crc_mis & end_ok;
                        state  <= (NCRC == 0) ? ST_STAT : ST_STAT_GAP;
                        cnt    <= '0;
                    end
                    ST_STAT_GAP: begin
                        if (cnt == NCRC_LAST) begin
                            state <= ST_STAT;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    ST_STAT: begin
                        if (cnt == 16'd4) begin
                            cnt <= '0;
                            if (crc_ok) begin
                                state <= ST_BUSY;
                            end else begin
                                state <= ST_IDLE;
                                done  <= 1'b1;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    ST_BUSY: begin
                        if (busy_last) begin
                            state <= ST_IDLE;
                            done  <= 1'b1;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    ST_TX_WAIT: begin
                        if (cnt == NAC_LAST) begin
                            state <= ST_TX_START;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    ST_TX_START: begin
                        state <= ST_TX_DAT;
                        cnt   <= '0;
                    end
                    ST_TX_DAT: begin
                        shreg <= tx_next;
                        if (data_last) begin
                            state <= ST_TX_CRC;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    ST_TX_CRC: begin
                        if (cnt[3:0] == 4'hF) begin
                            state <= ST_TX_END;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    ST_TX_END: begin
                        state <= ST_IDLE;
                        done  <= 1'b1;
                        cnt   <= '0;
                    end
                    default: begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sd_data_serial_card.sv
`default_nettype none
// tb_sd_data_serial_card -- scoreboard bench for the card-side DAT engine.
module tb_sd_data_serial_card;

    localparam int NAC  = 2;
    localparam int NCRC = 2;

    logic        sd_clk;
    logic        rst_n;
    logic [3:0]  DAT_dat_i;
    logic [3:0]  DAT_dat_o;
    logic        DAT_oe_o;
    logic        bus_width;
    logic [11:0] blksize;
    logic        start_rx;
    logic        start_tx;
    logic        abort;
    logic [7:0]  busy_cycles;
    logic [7:0]  rx_data;
    logic        rx_we;
    logic [7:0]  tx_data;
    logic        tx_rd;
    logic        done;
    logic        crc_ok;
    logic        busy;

    sd_data_serial_card #(.NAC(NAC), .NCRC(NCRC)) dut (
        .sd_clk      (sd_clk),
        .rst_n       (rst_n),
        .DAT_dat_i   (DAT_dat_i),
        .DAT_dat_o   (DAT_dat_o),
        .DAT_oe_o    (DAT_oe_o),
        .bus_width   (bus_width),
        .blksize     (blksize),
        .start_rx    (start_rx),
        .start_tx    (start_tx),
        .abort       (abort),
        .busy_cycles (busy_cycles),
        .rx_data     (rx_data),
        .rx_we       (rx_we),
        .tx_data     (tx_data),
        .tx_rd       (tx_rd),
        .done        (done),
        .crc_ok      (crc_ok),
        .busy        (busy)
    );

    initial sd_clk = 1'b0;
    always #5 sd_clk = ~sd_clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Show-ahead read FIFO model.
    logic [7:0]  fifo_mem [0:2047];
    logic [10:0] rd_ptr = '0;
    assign tx_data = fifo_mem[rd_ptr];
    always @(posedge sd_clk) if (tx_rd) rd_ptr <= rd_ptr + 11'd1;

    logic [7:0] blk [0:2047];
    logic [7:0] rx_q [$];

    always @(negedge sd_clk) begin
        if (rx_we) begin
            if (rx_q.size() == 0) check("rx_extra", 32'd1, 32'd0);
            else check("rx_data", 32'(rx_data), 32'(rx_q.pop_front()));
        end
    end

    function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic b);
        logic [15:0] n;
        n = {c[14:0], 1'b0};
        if (b ^ c[15]) n = n ^ 16'h1021;
        return n;
    endfunction

    task automatic write_block(input logic bw, input int nbytes, input logic flip,
                               input logic [7:0] bcyc, input int rst_at);
        logic [15:0] crc [4];
        logic [3:0]  d, act;
        logic        resp_q [$];
        logic        ok;
        int          gap, n_oe, n_done;
        bit          seen_oe, stopped;
        ok  = ~flip;
        act = bw ? 4'hF : 4'h1;
        for (int i = 0; i < 4; i++) crc[i] = 16'h0000;
        @(negedge sd_clk);
        bus_width = bw; blksize = 12'(nbytes); busy_cycles = bcyc; start_rx = 1'b1;
        @(negedge sd_clk);
        start_rx = 1'b0;
        repeat (2) @(negedge sd_clk);
        DAT_dat_i = ~act;
        for (int k = 0; k < nbytes; k++) begin
            rx_q.push_back(blk[k]);
            for (int s = 0; s < (bw ? 2 : 8); s++) begin
                d = bw ? ((s == 0) ? blk[k][7:4] : blk[k][3:0]) : {3'b111, blk[k][7-s]};
                @(negedge sd_clk);
                DAT_dat_i = d;
                for (int i = 0; i < 4; i++) if (act[i]) crc[i] = crc_upd(crc[i], d[i]);
            end
        end
        for (int j = 15; j >= 0; j--) begin
            for (int i = 0; i < 4; i++) d[i] = act[i] ? crc[i][j] : 1'b1;
            if (flip && j == 0) d[0] = ~d[0];
            @(negedge sd_clk);
            DAT_dat_i = d;
        end
        @(negedge sd_clk);
        DAT_dat_i = 4'hF;
        resp_q.push_back(1'b0);
        resp_q.push_back(~ok);
        resp_q.push_back(ok);
        resp_q.push_back(~ok);
        resp_q.push_back(1'b1);
        if (ok) repeat ((bcyc == 8'd0) ? 1 : int'(bcyc)) resp_q.push_back(1'b0);
        gap = 0; n_oe = 0; n_done = 0; seen_oe = 0; stopped = 0;
        for (int t = 0; t < 400 && n_done == 0 && !stopped; t++) begin
            @(negedge sd_clk);
            if (DAT_oe_o) begin
                if (!seen_oe) begin
                    check("wr_ncrc_gap", 32'(gap), 32'(NCRC));
                    seen_oe = 1;
                end
                check("wr_dat_hi", 32'(DAT_dat_o[3:1]), 32'h7);
                if (resp_q.size() == 0) check("wr_resp_extra", 32'd1, 32'd0);
                else check("wr_resp_bit", 32'(DAT_dat_o[0]), 32'(resp_q.pop_front()));
                n_oe++;
                if (n_oe == rst_at) begin
                    #2 rst_n = 1'b0;
                    #1;
                    check("rst_oe", 32'(DAT_oe_o), 32'd0);
                    check("rst_dat", 32'(DAT_dat_o), 32'hF);
                    check("rst_busy", 32'(busy), 32'd0);
                    check("rst_done", 32'(done), 32'd0);
                    check("rst_crc_ok", 32'(crc_ok), 32'd0);
                    check("rst_rx_we", 32'(rx_we), 32'd0);
                    check("rst_rx_data", 32'(rx_data), 32'd0);
                    check("rst_tx_rd", 32'(tx_rd), 32'd0);
                    @(negedge sd_clk);
                    rst_n = 1'b1;
                    resp_q.delete();
                    stopped = 1;
                end
            end else if (!seen_oe) begin
                gap++;
            end
            if (done) n_done++;
        end
        if (rst_at < 0) begin
            check("wr_done", 32'(n_done), 32'd1);
            check("wr_crc_ok", 32'(crc_ok), 32'(ok));
            check("wr_resp_len", 32'(resp_q.size()), 32'd0);
            @(negedge sd_clk);
            check("wr_done_pulse", 32'(done), 32'd0);
            check("wr_busy_end", 32'(busy), 32'd0);
        end
        check("wr_rx_left", 32'(rx_q.size()), 32'd0);
    endtask

    task automatic read_block(input logic bw, input int nbytes, input int abort_at,
                              input logic exp_crc_ok);
        logic [15:0] crc [4];
        logic [3:0]  d, act;
        logic [3:0]  exp_q [$];
        logic [10:0] base;
        int          n_oe, n_rd, n_done, n_bad;
        bit          stop;
        act  = bw ? 4'hF : 4'h1;
        base = rd_ptr;
        for (int i = 0; i < 4; i++) crc[i] = 16'h0000;
        for (int k = 0; k < nbytes; k++) fifo_mem[base + 11'(k)] = blk[k];
        repeat (NAC) exp_q.push_back(4'hF);
        exp_q.push_back(~act);
        for (int k = 0; k < nbytes; k++) begin
            for (int s = 0; s < (bw ? 2 : 8); s++) begin
                d = bw ? ((s == 0) ? blk[k][7:4] : blk[k][3:0]) : {3'b111, blk[k][7-s]};
                exp_q.push_back(d);
                for (int i = 0; i < 4; i++) if (act[i]) crc[i] = crc_upd(crc[i], d[i]);
            end
        end
        for (int j = 15; j >= 0; j--) begin
            for (int i = 0; i < 4; i++) d[i] = act[i] ? crc[i][j] : 1'b1;
            exp_q.push_back(d);
        end
        exp_q.push_back(4'hF);
        @(negedge sd_clk);
        bus_width = bw; blksize = 12'(nbytes); start_tx = 1'b1;
        n_oe = 0; n_rd = 0; n_done = 0; stop = 0;
        for (int t = 0; t < 200 + nbytes * 10 && n_done == 0 && !stop; t++) begin
            @(negedge sd_clk);
            start_tx = 1'b0;
            if (tx_rd) n_rd++;
            if (DAT_oe_o) begin
                if (exp_q.size() == 0) check("rd_extra", 32'd1, 32'd0);
                else check("rd_dat", 32'(DAT_dat_o), 32'(exp_q.pop_front()));
                if (abort_at >= 0 && n_oe == NAC + 1 + abort_at) begin
                    abort = 1'b1;
                    @(negedge sd_clk);
                    check("ab_oe", 32'(DAT_oe_o), 32'd0);
                    check("ab_busy", 32'(busy), 32'd0);
                    abort = 1'b0;
                    n_bad = 0;
                    repeat (20) begin
                        if (done || DAT_oe_o || tx_rd) n_bad++;
                        @(negedge sd_clk);
                    end
                    check("ab_quiet", 32'(n_bad), 32'd0);
                    check("ab_crc_ok", 32'(crc_ok), 32'(exp_crc_ok));
                    stop = 1;
                end
                n_oe++;
            end
            if (done) n_done++;
        end
        if (abort_at < 0) begin
            check("rd_done", 32'(n_done), 32'd1);
            check("rd_len", 32'(exp_q.size()), 32'd0);
            check("rd_pops", 32'(n_rd), 32'(nbytes));
            check("rd_ptr", 32'(11'(rd_ptr - base)), 32'(nbytes));
            check("rd_busy_end", 32'(busy), 32'd0);
        end
    endtask

    initial begin
        int n_bad;
        rst_n = 1'b0; DAT_dat_i = 4'hF; bus_width = 1'b0; blksize = 12'd1;
        start_rx = 1'b0; start_tx = 1'b0; abort = 1'b0; busy_cycles = 8'd0;
        for (int i = 0; i < 2048; i++) fifo_mem[i] = 8'h00;
        repeat (3) @(negedge sd_clk);
        check("rst0_oe", 32'(DAT_oe_o), 32'd0);
        check("rst0_dat", 32'(DAT_dat_o), 32'hF);
        check("rst0_rx_we", 32'(rx_we), 32'd0);
        check("rst0_rx_data", 32'(rx_data), 32'd0);
        check("rst0_tx_rd", 32'(tx_rd), 32'd0);
        check("rst0_done", 32'(done), 32'd0);
        check("rst0_crc_ok", 32'(crc_ok), 32'd0);
        check("rst0_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge sd_clk);

        // 1-bit write of 512 x 0xFF, good CRC, then with the CRC LSB flipped.
        for (int k = 0; k < 512; k++) blk[k] = 8'hFF;
        write_block(1'b0, 512, 1'b0, 8'd8, -1);
        write_block(1'b0, 512, 1'b1, 8'd8, -1);

        // 4-bit write of random bytes with busy_cycles=0 (one busy cycle).
        for (int k = 0; k < 8; k++) blk[k] = 8'($urandom);
        write_block(1'b1, 8, 1'b0, 8'd0, -1);

        // 4-bit read 12 34 56 78, then 1-bit read A5 3C.
        blk[0] = 8'h12; blk[1] = 8'h34; blk[2] = 8'h56; blk[3] = 8'h78;
        read_block(1'b1, 4, -1, 1'b1);
        blk[0] = 8'hA5; blk[1] = 8'h3C;
        read_block(1'b0, 2, -1, 1'b1);

        // Abort at data cycle 100 of a 1-bit read.
        for (int k = 0; k < 64; k++) blk[k] = 8'($urandom);
        read_block(1'b0, 64, 100, 1'b1);

        // Simultaneous start_rx/start_tx: receive wins, later start_tx ignored.
        @(negedge sd_clk);
        bus_width = 1'b0; blksize = 12'd1; start_rx = 1'b1; start_tx = 1'b1;
        @(negedge sd_clk);
        start_rx = 1'b0; start_tx = 1'b0;
        check("both_busy", 32'(busy), 32'd1);
        check("both_oe", 32'(DAT_oe_o), 32'd0);
        n_bad = 0;
        for (int t = 0; t < 6; t++) begin
            start_tx = (t == 2);
            @(negedge sd_clk);
            if (tx_rd || DAT_oe_o) n_bad++;
        end
        start_tx = 1'b0;
        check("both_quiet", 32'(n_bad), 32'd0);
        abort = 1'b1;
        @(negedge sd_clk);
        abort = 1'b0;
        check("both_abort_idle", 32'(busy), 32'd0);

        // Reset asserted in the middle of BUSY.
        for (int k = 0; k < 4; k++) blk[k] = 8'($urandom);
        write_block(1'b0, 4, 1'b0, 8'd50, 10);

        repeat (2) @(negedge sd_clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/sd_data_serial_card.md
SD_DATA_SERIAL_CARD -- requirements
Module: sd_data_serial_card

Card-side DAT-line engine: receives host write blocks and returns CRC status and busy; transmits read blocks.

Interface
REQ-001 SHALL have parameter NAC, default 2, giving the count of idle cycles, DAT driven 1, between start_tx and the read start bit.
REQ-002 SHALL have parameter NCRC, default 2, giving the count of undriven cycles between the write end bit and the CRC status token.
REQ-003 Ports:
- sd_clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- DAT_dat_i  in  4  sampled DAT lines.
- DAT_dat_o  out  4  driven DAT value.
- DAT_oe_o  out  1  DAT output enable.
- bus_width  in  1  0 = DAT0 only; 1 = DAT[3:0].
- blksize  in  12  block length in bytes, 1..2048.
- start_rx  in  1  one-cycle pulse that arms reception of one write block.
- start_tx  in  1  one-cycle pulse that sends one read block.
- abort  in  1  level; forces return to IDLE.
- busy_cycles  in  8  DAT0-low busy length after a write.
- rx_data  out  8  received byte.
- rx_we  out  1  one-cycle strobe; rx_data valid.
- tx_data  in  8  show-ahead FIFO head byte.
- tx_rd  out  1  pops tx_data.
- done  out  1  one-cycle pulse at block end.
- crc_ok  out  1  result of last write; held until next start_rx.
- busy  out  1  high whenever state is not IDLE.

Function
REQ-004 SHALL implement states IDLE, RX_WAIT, RX_DAT, RX_CRC, RX_END, STAT_GAP, STAT, BUSY, TX_WAIT, TX_START, TX_DAT, TX_CRC, TX_END.
REQ-005 IDLE transitions:
- start_rx -> RX_WAIT; start_tx -> TX_WAIT.
- If both assert together, start_rx SHALL win.
- start_rx/start_tx outside IDLE SHALL be ignored.
REQ-006 RX_WAIT SHALL leave when DAT_dat_i[0]=0 (1-bit mode) or DAT_dat_i=4'b0000 (4-bit mode).
REQ-007 Data cycles per block: D = blksize*8 (1-bit) or blksize*2 (4-bit).
REQ-008 RX_DAT SHALL run D cycles.
- Bits are MSB first; in 4-bit mode the high nibble comes first, DAT[3] carrying bit 7/3.
- rx_we pulses the cycle after each byte completes.
REQ-009 CRC format:
- One CRC16 per active line, polynomial x^16+x^12+x^5+1, initial value 0.
- RX_CRC runs 16 cycles and compares MSB first.
- In 1-bit mode lines 1..3 are ignored.
REQ-010 RX_END SHALL sample the end bit. crc_ok=1 only if all active CRCs match and the end bit is 1.
REQ-011 STAT_GAP SHALL last NCRC cycles with DAT_oe_o=0.
REQ-012 STAT SHALL drive DAT0 for 5 cycles: 0, then 010 (crc_ok) or 101 (fail), then 1.
- DAT_dat_o[3:1]=4'b111 pattern bits held 1 throughout.
- If crc_ok=0, go to IDLE with done pulsed; else go to BUSY.
REQ-013 BUSY SHALL drive DAT0=0 for max(busy_cycles,1) cycles, then pulse done and go to IDLE.
REQ-014 TX_WAIT SHALL last NAC cycles driving all lines 1 with DAT_oe_o=1.
REQ-015 TX_START SHALL drive 0 on the active lines for one cycle.
REQ-016 TX_DAT SHALL drive D cycles in the same bit order as REQ-008.
- tx_rd pulses in the cycle a byte's final bit is driven.
- tx_data is sampled when a byte's first bit is driven.
- Inactive lines are driven 1.
REQ-017 TX_CRC SHALL drive the 16 CRC bits MSB first. TX_END SHALL drive 1 for one cycle, pulse done, then go to IDLE.
REQ-018 abort in any state SHALL go to IDLE next cycle.
- DAT_oe_o=0; no done pulse; no rx_we/tx_rd issued after that edge; crc_ok unchanged.
REQ-019 In IDLE, RX_WAIT, RX_DAT, RX_CRC, RX_END and STAT_GAP, DAT_oe_o=0. In IDLE, DAT_dat_o=4'b1111.
REQ-020 All counters SHALL be at least 14 bits wide (D ≤ 16384); no wrap-around within a block.

Reset
REQ-021 On rst_n low: state=IDLE; DAT_oe_o=0, DAT_dat_o=4'b1111, rx_we=0, rx_data=0, tx_rd=0, done=0, crc_ok=0, busy=0; CRC registers cleared.
REQ-022 Reset asserted mid-block SHALL release DAT immediately, not waiting for the next sd_clk edge.

Structure
REQ-023 State encodings and the NAC/NCRC defaults SHALL live in a shared sd package/defines file alongside SD_BUS_W.
REQ-024 SHALL instantiate four copies of the existing sd_crc_16, one per line, cleared in IDLE and at each RX_WAIT/TX_START.

Verification
REQ-025 1-bit write, blksize=512, all 0xFF, CRC 0x7FA1 -> 512 rx_we strobes of 0xFF, crc_ok=1, token 0-010-1, DAT0 low busy_cycles cycles, done.
REQ-026 Same with the CRC LSB flipped -> crc_ok=0, token 0-101-1, no BUSY, done.
REQ-027 4-bit read, blksize=4, bytes 0x12 0x34 0x56 0x78 -> after NAC=2 ones: start 0000, nibbles 1,2,3,4,5,6,7,8, per-line CRC, end 1111, 4 tx_rd pulses, done.
REQ-028 start_rx and start_tx in the same cycle -> RX_WAIT entered, no tx_rd.
REQ-029 abort at data cycle 100 of a read -> DAT_oe_o=0 next cycle, busy=0, no done.
REQ-030 rst_n low mid-BUSY -> DAT_oe_o=0 asynchronously; all outputs at REQ-021 values.
